// File: rtl/msi_arb_pkg.sv
// Shared types and constants for the MSI interrupt arbiter.
package msi_arb_pkg;

  // Width of the MSI vector number presented to the PCIe core.
  localparam int MSI_VEC_W = 5;

  // IDLE: nothing requested; REQ: msi_request high for one source;
  // GAP: one forced low cycle after a grant or a timeout.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set bit of pending_i
// found by scanning upward from ptr_i and wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  pending_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  int              j;
  logic [PW-1:0]   jj;

  // Rotating priority scan; the first hit from ptr_i wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      jj = PW'(j);
      if (!valid_o && pending_i[jj]) begin
        valid_o = 1'b1;
        idx_o   = jj;
      end
    end
  end

endmodule

// File: rtl/msi_int_arbiter.sv
// MSI interrupt arbiter: latches rising edges of level interrupt lines into
// pending bits and hands them to the PCIe core one MSI at a time, round-robin.
// Optional feature macro: MSI_ARB_TIMEOUT_EN (abandon a request after TIMEOUT
// cycles without grant and move on to the next source).
// Handshake: msi_request is held high with a stable msi_vector_num until a
// one-cycle msi_grant pulse is sampled in REQ; grant is ignored elsewhere.
module msi_int_arbiter
  import msi_arb_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 axi_clk_pcie,
  input  logic                 sys_resetn,
  input  logic [N_SRC-1:0]     irq_i,
  input  logic [N_SRC-1:0]     src_en_i,
  input  logic                 msi_enabled,
  input  logic                 msi_grant,
  output logic                 msi_request,
  output logic [MSI_VEC_W-1:0] msi_vector_num,
  output logic [N_SRC-1:0]     pending_o,
  output arb_state_e           dbg_state_o
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  arb_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic [PW-1:0]    vec_q, vec_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] irq_q, irq_d;
  logic             armed_q, armed_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr_mask;
  logic [PW-1:0]    nxt_ptr;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;
  logic             to_hit;

`ifdef MSI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rr_pick #(
    .N  (N_SRC),
    .PW (PW)
  ) u_rr_pick (
    .pending_i (pending_q),
    .ptr_i     (ptr_q),
    .idx_o     (pick_idx),
    .valid_o   (pick_valid)
  );

  // Edge detection and pending bits. armed_q masks the first cycle after
  // reset so a line already high at release is not taken as an edge; a rise
  // in the grant cycle wins over the clear.
  always_comb begin
    irq_d     = irq_i;
    armed_d   = 1'b1;
    rise      = irq_i & ~irq_q & {N_SRC{armed_q}};
    pending_d = (pending_q & ~clr_mask) | (rise & src_en_i);
  end

  // Pointer to the source after the one currently held in vec_q.
  always_comb begin
    nxt_ptr = (vec_q == PW'(N_SRC - 1)) ? '0 : vec_q + PW'(1);
  end

`ifdef MSI_ARB_TIMEOUT_EN
  // Cycles spent in REQ; fires on the last permitted cycle.
  always_comb begin
    to_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    cnt_d  = ((state_q == REQ) && (state_d == REQ)) ? cnt_q + CNT_W'(1) : '0;
  end
`else
  // Without the timeout feature REQ waits for a grant indefinitely.
  always_comb begin
    to_hit = 1'b0;
  end
`endif

  // Next-state and request logic. A grant in the same cycle that msi_enabled
  // falls is honoured, since the core has already accepted the message.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    vec_d    = vec_q;
    ptr_d    = ptr_q;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (msi_enabled && pick_valid) begin
          state_d = REQ;
          req_d   = 1'b1;
          vec_d   = pick_idx;
        end
      end
      REQ: begin
        if (msi_grant) begin
          state_d         = GAP;
          req_d           = 1'b0;
          clr_mask[vec_q] = 1'b1;
          ptr_d           = nxt_ptr;
        end else if (!msi_enabled) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (to_hit) begin
          state_d = GAP;
          req_d   = 1'b0;
          ptr_d   = nxt_ptr;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge axi_clk_pcie or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      vec_q     <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      irq_q     <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      vec_q     <= vec_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      armed_q   <= armed_d;
    end
  end

`ifdef MSI_ARB_TIMEOUT_EN
  // Timeout counter register.
  always_ff @(posedge axi_clk_pcie or negedge sys_resetn) begin
    if (!sys_resetn) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end
`endif

  assign msi_request    = req_q;
  assign msi_vector_num = MSI_VEC_W'(vec_q);
  assign pending_o      = pending_q;
  assign dbg_state_o    = state_q;

endmodule
